zap_tlb_assoc: RTL and testbench
================================

Name: zap_tlb_assoc

Overview:
- Parametrised, fully-associative unified TLB; successor to the per-page-size direct-mapped TLB arrays.
- One CAM holds section (1MB), large (64KB), small (4KB) and tiny (1KB) translations; matching uses per-entry size masks.
- Adds allocation that prefers invalid entries, fill de-duplication, selectable replacement, and invalidate-by-VA alongside invalidate-all.
- Sits between the cache FSM (lookup) and the page-table walker (fill). Permission/domain checking stays downstream.

Parameters:
- ENTRIES, 16: number of TLB entries; power of two, 2..64.
- IDX_W, $clog2(ENTRIES): entry index width; derived, do not override.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous reset, active-low.
- i_hold  in  1  freezes lookup output registers.
- i_lkp_valid  in  1  lookup request.
- i_lkp_va  in  32  lookup virtual address.
- o_hit  out  1  registered lookup hit.
- o_miss  out  1  registered lookup miss.
- o_phy_addr  out  32  translated physical address.
- o_ap  out  2  access permission for the addressed subpage.
- o_dom  out  4  domain.
- o_cb  out  2  {cacheable, bufferable}.
- o_size  out  2  page size of the hit entry.
- i_fill_valid  in  1  write a translation.
- i_fill_va  in  32  VA of the fill.
- i_fill_size  in  2  0=section, 1=large, 2=small, 3=tiny.
- i_fill_pa  in  22  PA[31:10].
- i_fill_ap  in  8  four 2-bit subpage APs.
- i_fill_dom  in  4  domain.
- i_fill_cb  in  2  C,B.
- i_inv_all  in  1  invalidate all entries.
- i_inv_va_valid  in  1  invalidate entries matching i_inv_va.
- i_inv_va  in  32  VA to invalidate.

Behaviour:
- Reset (async, i_reset_n=0): all valid bits 0; o_hit, o_miss, o_phy_addr, o_ap, o_dom, o_cb, o_size = 0; replacement state 0.
- Entry match: valid & (va[31:S] == tag[31:S]). S = 20 (section), 16 (large), 12 (small), 10 (tiny).
- Lookup latency: 1 cycle. When i_lkp_valid & !i_hold, the outputs register at the next edge.
  - o_hit=1 when any entry matches; o_miss = !hit. Both are 0 the cycle after no request.
  - If several entries match, the lowest index wins.
- Physical address on hit: {pa[31:S], va[S-1:0]}.
- AP on hit: large uses ap[va[15:14]]; small uses ap[va[11:10]]; section/tiny use ap[1:0].
- i_hold=1: all outputs hold their values and the lookup is ignored. Fills and invalidates still apply.
- Fill (i_fill_valid=1): writes at the next edge.
  - If i_fill_va matches an existing valid entry, that entry is overwritten; replacement state does not change.
  - Otherwise the fill goes to the lowest-index invalid entry.
  - If no entry is invalid, the fill goes to the victim from zap_tlb_victim_sel, and the victim state updates.
- i_inv_all: clears every valid bit in one cycle.
- i_inv_va_valid: clears all entries that match i_inv_va under their own size mask, in one cycle.
- Same-cycle priority:
  - i_inv_all beats fill; the fill is dropped.
  - Fill beats inv_va when both hit the target entry; the entry ends up valid with the new contents.
  - A lookup sees pre-edge contents: a lookup in the same cycle as the fill of that VA returns a miss.
- Round-robin pointer: advances by 1 on each victim allocation and wraps ENTRIES-1 -> 0. Any hit updates PLRU (feature on).
- Reset asserted mid-fill: the fill is discarded; the entry stays invalid.

Optional Feature:
- Macro ZAP_TLB_PLRU_EN.
- Defined: tree pseudo-LRU with ENTRIES-1 bits.
  - Updated on a lookup hit (to the hit index) and on a victim fill (to the filled index).
  - The victim is found by walking the tree away from recent use.
- Undefined: round-robin pointer; hits do not affect replacement.

Decomposition:
- Package zap_tlb_pkg:
  - page_size_t enum (SECTION, LPAGE, SPAGE, FPAGE).
  - tlb_entry_t struct {valid, tag[31:10], size, pa[31:10], ap[7:0], dom, cb}.
  - Function size_to_shift(page_size_t) returning 20/16/12/10.
- Sub-module zap_tlb_victim_sel (ENTRIES): holds the round-robin or PLRU state.
  - Inputs: alloc strobe, touch strobe, touch index.
  - Output: victim index.

Test Plan:
- Reset then lookup VA 0x0000_1234 -> next cycle o_miss=1, o_hit=0, o_phy_addr=0.
- Fill section VA 0x1230_0000 -> PA 0x8000_0000 (pa=22'h200000), then lookup 0x123A_BCDE -> o_hit=1, o_phy_addr=0x800A_BCDE, o_size=0.
- Fill large page ap=8'b11_10_01_00, then look up 4 subpages (va[15:14]=0..3) -> o_ap = 00, 01, 10, 11.
- Fill ENTRIES+1 distinct small pages without macro -> the last fill replaces entry 0. Refill the same VA -> no new allocation; the pointer stays at 1.
- Fill 4 tiny pages, then i_inv_va on the second -> it misses and the other three hit. i_inv_all with a simultaneous fill -> all entries miss afterwards.
- Assert i_hold with a new lookup -> outputs unchanged. Fill during hold, release, then look up -> hit.

Source files
------------

// File: rtl/zap_tlb_pkg.sv
// Shared types and helpers for the unified fully-associative TLB.
// Page sizes, the CAM entry layout and size-dependent tag masks live here.
package zap_tlb_pkg;

   typedef enum logic [1:0] {
      SECTION = 2'd0,
      LPAGE   = 2'd1,
      SPAGE   = 2'd2,
      FPAGE   = 2'd3
   } page_size_t;

   typedef struct packed {
      logic        valid;
      logic [21:0] tag;   // VA[31:10]
      page_size_t  size;
      logic [21:0] pa;    // PA[31:10]
      logic [7:0]  ap;
      logic [3:0]  dom;
      logic [1:0]  cb;
   } tlb_entry_t;

   function automatic logic [4:0] size_to_shift(input page_size_t s);
      case (s)
         SECTION: return 5'd20;
         LPAGE:   return 5'd16;
         SPAGE:   return 5'd12;
         default: return 5'd10;
      endcase
   endfunction

   // Mask over VA/PA bits [31:10] that take part in the page-number compare.
   function automatic logic [21:0] size_mask(input page_size_t s);
      return 22'h3F_FFFF << (size_to_shift(s) - 5'd10);
   endfunction

endpackage

// File: rtl/zap_tlb_victim_sel.sv
// Replacement state for the TLB: round-robin pointer by default, tree
// pseudo-LRU when ZAP_TLB_PLRU_EN is defined.
module zap_tlb_victim_sel #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_alloc,
   input  logic             i_touch,
   input  logic [IDX_W-1:0] i_touch_idx,
   output logic [IDX_W-1:0] o_victim
);

`ifdef ZAP_TLB_PLRU_EN
   logic [ENTRIES-2:0] r_tree;
   logic [ENTRIES-2:0] w_tree_nxt;

   // Each node bit points toward the less recently used subtree (0=left).
   function automatic logic [ENTRIES-2:0] plru_touch(input logic [ENTRIES-2:0] t,
                                                     input logic [IDX_W-1:0]   idx);
      logic [ENTRIES-2:0] n;
      int                 node;
      n    = t;
      node = 0;
      for (int l = 0; l < IDX_W; l++) begin
         n[node] = ~idx[IDX_W-1-l];
         node    = 2 * node + 1 + int'(idx[IDX_W-1-l]);
      end
      return n;
   endfunction

   always_comb begin
      int node;
      node = 0;
      for (int l = 0; l < IDX_W; l++) begin
         node = 2 * node + 1 + int'(r_tree[node]);
      end
      o_victim = IDX_W'(node - (ENTRIES - 1));
   end

   // NOTE: always_comb uses blocking '=' so later statements see the update;
   // registered state below always uses '<=' to avoid ordering races.
   always_comb begin
      w_tree_nxt = r_tree;
      if (i_touch) w_tree_nxt = plru_touch(w_tree_nxt, i_touch_idx);
      if (i_alloc) w_tree_nxt = plru_touch(w_tree_nxt, o_victim);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_tree <= '0;
      else            r_tree <= w_tree_nxt;
   end
`else
   logic [IDX_W-1:0] r_ptr;
   logic             w_unused_touch;

   assign w_unused_touch = ^{i_touch, i_touch_idx};
   assign o_victim       = r_ptr;

   // ENTRIES is a power of two, so the natural overflow is the wrap.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)   r_ptr <= '0;
      else if (i_alloc) r_ptr <= r_ptr + 1'b1;
   end
`endif

endmodule

// File: rtl/zap_tlb_assoc.sv
// Fully-associative unified TLB (section/large/small/tiny pages) with fill
// de-duplication, invalid-first allocation and invalidate-by-VA.
// Replacement policy: round-robin, or tree PLRU with ZAP_TLB_PLRU_EN defined.
module zap_tlb_assoc
   import zap_tlb_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_hold,
   input  logic        i_lkp_valid,
   input  logic [31:0] i_lkp_va,
   output logic        o_hit,
   output logic        o_miss,
   output logic [31:0] o_phy_addr,
   output logic [1:0]  o_ap,
   output logic [3:0]  o_dom,
   output logic [1:0]  o_cb,
   output logic [1:0]  o_size,
   input  logic        i_fill_valid,
   input  logic [31:0] i_fill_va,
   input  logic [1:0]  i_fill_size,
   input  logic [21:0] i_fill_pa,
   input  logic [7:0]  i_fill_ap,
   input  logic [3:0]  i_fill_dom,
   input  logic [1:0]  i_fill_cb,
   input  logic        i_inv_all,
   input  logic        i_inv_va_valid,
   input  logic [31:0] i_inv_va
);

   tlb_entry_t r_tlb [ENTRIES];

   logic             r_hit, r_miss;
   logic [31:0]      r_phy_addr;
   logic [1:0]       r_ap, r_cb;
   logic [3:0]       r_dom;
   page_size_t       r_size;

   logic [ENTRIES-1:0] w_lkp_match, w_fill_match, w_inv_match;
   logic               w_hit, w_dup, w_has_free;
   logic [IDX_W-1:0]   w_hit_idx, w_dup_idx, w_free_idx, w_victim, w_fill_idx;
   logic               w_fill_go, w_alloc, w_touch;
   tlb_entry_t         w_hit_e, w_new;
   logic [31:0]        w_mask, w_phy;
   logic [1:0]         w_ap_sel;
   logic               w_unused_va;

   assign w_unused_va = ^{i_inv_va[9:0], i_fill_va[9:0]};

   function automatic logic ent_match(input tlb_entry_t e, input logic [21:0] vpn);
      return e.valid && (((vpn ^ e.tag) & size_mask(e.size)) == '0);
   endfunction

   always_comb begin
      w_lkp_match = '0;
      w_fill_match = '0;
      w_inv_match = '0;
      w_hit = 1'b0;  w_hit_idx  = '0;
      w_dup = 1'b0;  w_dup_idx  = '0;
      w_has_free = 1'b0; w_free_idx = '0;
      // Scan high to low so the lowest matching index is the one kept.
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         w_lkp_match[i]  = ent_match(r_tlb[i], i_lkp_va[31:10]);
         w_fill_match[i] = ent_match(r_tlb[i], i_fill_va[31:10]);
         w_inv_match[i]  = i_inv_va_valid && ent_match(r_tlb[i], i_inv_va[31:10]);
         if (w_lkp_match[i])  begin w_hit = 1'b1;      w_hit_idx  = IDX_W'(i); end
         if (w_fill_match[i]) begin w_dup = 1'b1;      w_dup_idx  = IDX_W'(i); end
         if (!r_tlb[i].valid) begin w_has_free = 1'b1; w_free_idx = IDX_W'(i); end
      end
   end

   assign w_fill_go  = i_fill_valid && !i_inv_all;
   assign w_alloc    = w_fill_go && !w_dup && !w_has_free;
   assign w_fill_idx = w_dup ? w_dup_idx : (w_has_free ? w_free_idx : w_victim);
   assign w_touch    = i_lkp_valid && !i_hold && w_hit;

   assign w_new = '{valid: 1'b1, tag: i_fill_va[31:10], size: page_size_t'(i_fill_size),
                    pa: i_fill_pa, ap: i_fill_ap, dom: i_fill_dom, cb: i_fill_cb};

   zap_tlb_victim_sel #(.ENTRIES(ENTRIES)) u_victim (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_alloc     (w_alloc),
      .i_touch     (w_touch),
      .i_touch_idx (w_hit_idx),
      .o_victim    (w_victim)
   );

   assign w_hit_e = r_tlb[w_hit_idx];
   assign w_mask  = {size_mask(w_hit_e.size), 10'h0};
   assign w_phy   = ({w_hit_e.pa, 10'h0} & w_mask) | (i_lkp_va & ~w_mask);

   always_comb begin
      w_ap_sel = 2'd0;
      case (w_hit_e.size)
         LPAGE:   w_ap_sel = i_lkp_va[15:14];
         SPAGE:   w_ap_sel = i_lkp_va[11:10];
         default: w_ap_sel = 2'd0;
      endcase
   end

   // NOTE: the entry array is built from flops, so it is cleared on reset like
   // any other register; only the valid bit matters but a full clear is cheap.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < ENTRIES; i++) r_tlb[i] <= '0;
      end else if (i_inv_all) begin
         for (int i = 0; i < ENTRIES; i++) r_tlb[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (i_fill_valid && (w_fill_idx == IDX_W'(i))) r_tlb[i] <= w_new;
            else if (w_inv_match[i])                         r_tlb[i].valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_hit      <= 1'b0;
         r_miss     <= 1'b0;
         r_phy_addr <= '0;
         r_ap       <= '0;
         r_dom      <= '0;
         r_cb       <= '0;
         r_size     <= SECTION;
      end else if (!i_hold) begin
         r_hit  <= i_lkp_valid && w_hit;
         r_miss <= i_lkp_valid && !w_hit;
         if (i_lkp_valid) begin
            r_phy_addr <= w_hit ? w_phy : '0;
            r_ap       <= w_hit ? w_hit_e.ap[{w_ap_sel, 1'b0} +: 2] : '0;
            r_dom      <= w_hit ? w_hit_e.dom : '0;
            r_cb       <= w_hit ? w_hit_e.cb : '0;
            r_size     <= w_hit ? w_hit_e.size : SECTION;
         end
      end
   end

   assign o_hit      = r_hit;
   assign o_miss     = r_miss;
   assign o_phy_addr = r_phy_addr;
   assign o_ap       = r_ap;
   assign o_dom      = r_dom;
   assign o_cb       = r_cb;
   assign o_size     = r_size;

endmodule

// File: tb/tb_zap_tlb_assoc.sv
// Scoreboard bench for zap_tlb_assoc (default build, round-robin replacement):
// stimulus pushes expected lookup responses, a monitor pops on each response.
module tb_zap_tlb_assoc;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_hold, i_lkp_valid;
   logic [31:0] i_lkp_va;
   logic        o_hit, o_miss;
   logic [31:0] o_phy_addr;
   logic [1:0]  o_ap, o_cb, o_size;
   logic [3:0]  o_dom;
   logic        i_fill_valid;
   logic [31:0] i_fill_va;
   logic [1:0]  i_fill_size;
   logic [21:0] i_fill_pa;
   logic [7:0]  i_fill_ap;
   logic [3:0]  i_fill_dom;
   logic [1:0]  i_fill_cb;
   logic        i_inv_all, i_inv_va_valid;
   logic [31:0] i_inv_va;

   always #5 i_clk = ~i_clk;

   zap_tlb_assoc dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_hold(i_hold),
      .i_lkp_valid(i_lkp_valid), .i_lkp_va(i_lkp_va),
      .o_hit(o_hit), .o_miss(o_miss), .o_phy_addr(o_phy_addr), .o_ap(o_ap),
      .o_dom(o_dom), .o_cb(o_cb), .o_size(o_size),
      .i_fill_valid(i_fill_valid), .i_fill_va(i_fill_va), .i_fill_size(i_fill_size),
      .i_fill_pa(i_fill_pa), .i_fill_ap(i_fill_ap), .i_fill_dom(i_fill_dom),
      .i_fill_cb(i_fill_cb), .i_inv_all(i_inv_all), .i_inv_va_valid(i_inv_va_valid),
      .i_inv_va(i_inv_va)
   );

   typedef struct {
      logic        hit;
      logic [31:0] pa;
      logic [1:0]  ap;
      logic [3:0]  dom;
      logic [1:0]  cb;
      logic [1:0]  size;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input bit ok, input string name, input string got, input string want);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %s, want %s", name, got, want);
      end
   endtask

   task automatic push(input string name, input logic hit, input logic [31:0] pa,
                       input logic [1:0] ap, input logic [3:0] dom,
                       input logic [1:0] cb, input logic [1:0] size);
      exp_t e;
      e.hit = hit; e.pa = pa; e.ap = ap; e.dom = dom; e.cb = cb; e.size = size; e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic lookup(input logic [31:0] va, input string name, input logic hit,
                         input logic [31:0] pa = '0, input logic [1:0] ap = '0,
                         input logic [3:0] dom = '0, input logic [1:0] cb = '0,
                         input logic [1:0] size = '0);
      i_lkp_valid = 1'b1;
      i_lkp_va    = va;
      push(name, hit, pa, ap, dom, cb, size);
   endtask

   task automatic fill(input logic [31:0] va, input logic [1:0] size, input logic [21:0] pa,
                       input logic [7:0] ap, input logic [3:0] dom, input logic [1:0] cb);
      i_fill_valid = 1'b1;
      i_fill_va = va; i_fill_size = size; i_fill_pa = pa;
      i_fill_ap = ap; i_fill_dom = dom; i_fill_cb = cb;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
      i_lkp_valid = 1'b0; i_fill_valid = 1'b0; i_inv_all = 1'b0;
      i_inv_va_valid = 1'b0; i_hold = 1'b0;
   endtask

   // Monitor: every registered response consumes exactly one expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (i_reset_n && (o_hit || o_miss)) begin
            if (sb_q.size() == 0) begin
               check(1'b0, "unexpected_resp",
                     $sformatf("hit=%0b miss=%0b pa=%h", o_hit, o_miss, o_phy_addr), "no response");
            end else begin
               e = sb_q.pop_front();
               check({o_hit, o_miss, o_phy_addr, o_ap, o_dom, o_cb, o_size} ==
                     {e.hit, !e.hit, e.pa, e.ap, e.dom, e.cb, e.size}, e.name,
                     $sformatf("hit=%0b miss=%0b pa=%h ap=%0d dom=%h cb=%0d size=%0d",
                               o_hit, o_miss, o_phy_addr, o_ap, o_dom, o_cb, o_size),
                     $sformatf("hit=%0b miss=%0b pa=%h ap=%0d dom=%h cb=%0d size=%0d",
                               e.hit, !e.hit, e.pa, e.ap, e.dom, e.cb, e.size));
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin : stimulus
      i_reset_n = 1'b0; i_hold = 1'b0; i_lkp_valid = 1'b0; i_lkp_va = '0;
      i_fill_valid = 1'b0; i_fill_va = '0; i_fill_size = '0; i_fill_pa = '0;
      i_fill_ap = '0; i_fill_dom = '0; i_fill_cb = '0;
      i_inv_all = 1'b0; i_inv_va_valid = 1'b0; i_inv_va = '0;
      #23;
      check(o_hit == 1'b0, "rst_hit", $sformatf("%0b", o_hit), "0");
      check(o_miss == 1'b0, "rst_miss", $sformatf("%0b", o_miss), "0");
      check({o_phy_addr, o_ap, o_dom, o_cb, o_size} == '0, "rst_data",
            $sformatf("pa=%h ap=%0d dom=%h cb=%0d size=%0d", o_phy_addr, o_ap, o_dom, o_cb, o_size),
            "all zero");
      @(negedge i_clk);
      i_reset_n = 1'b1;
      tick();

      lookup(32'h0000_1234, "rst_lookup_miss", 1'b0); tick();

      fill(32'h1230_0000, 2'd0, 22'h200000, 8'hE7, 4'h5, 2'b10); tick();
      lookup(32'h123A_BCDE, "section_hit", 1'b1, 32'h800A_BCDE, 2'b11, 4'h5, 2'b10, 2'd0); tick();

      fill(32'h4567_0000, 2'd1, 22'h26AF00, 8'hE4, 4'h3, 2'b01); tick();
      for (int k = 0; k < 4; k++) begin
         lookup(32'h4567_0123 | (k << 14), $sformatf("large_ap%0d", k), 1'b1,
                32'h9ABC_0123 | (k << 14), 2'(k), 4'h3, 2'b01, 2'd1);
         tick();
      end
      tick();
      @(negedge i_clk);
      check(!o_hit && !o_miss, "idle_no_resp", $sformatf("hit=%0b miss=%0b", o_hit, o_miss),
            "hit=0 miss=0");

      // Round-robin: fill every entry, then one more evicts entry 0.
      i_inv_all = 1'b1; tick();
      for (int i = 0; i < 16; i++) begin
         fill(32'h0010_0000 + (i << 12), 2'd2, 22'h280000 + 22'(4 * i), 8'h1B, 4'h0, 2'b00);
         tick();
      end
      fill(32'h0020_0000, 2'd2, 22'h2C0000, 8'h1B, 4'h0, 2'b00); tick();
      lookup(32'h0010_0ABC, "rr_evicted_e0", 1'b0); tick();
      lookup(32'h0010_1ABC, "rr_kept_e1", 1'b1, 32'hA000_1ABC, 2'b01, 4'h0, 2'b00, 2'd2); tick();
      lookup(32'h0020_0345, "rr_new_fill", 1'b1, 32'hB000_0345, 2'b11, 4'h0, 2'b00, 2'd2); tick();
      fill(32'h0020_0000, 2'd2, 22'h300000, 8'h1B, 4'h0, 2'b00); tick();
      fill(32'h0030_0000, 2'd2, 22'h340000, 8'h1B, 4'h0, 2'b00); tick();
      lookup(32'h0010_1ABC, "rr_ptr_at_1", 1'b0); tick();
      lookup(32'h0020_0345, "rr_dedup_pa", 1'b1, 32'hC000_0345, 2'b11, 4'h0, 2'b00, 2'd2); tick();
      lookup(32'h0010_2ABC, "rr_kept_e2", 1'b1, 32'hA000_2ABC, 2'b01, 4'h0, 2'b00, 2'd2); tick();
      lookup(32'h0030_0345, "rr_second_victim", 1'b1, 32'hD000_0345, 2'b11, 4'h0, 2'b00, 2'd2); tick();

      // Tiny pages and invalidate-by-VA.
      i_inv_all = 1'b1; tick();
      for (int k = 0; k < 4; k++) begin
         fill(32'h0050_0000 + (k << 10), 2'd3, 22'h380000 + 22'(k), 8'h02, 4'hA, 2'b11);
         tick();
      end
      i_inv_va_valid = 1'b1; i_inv_va = 32'h0050_0555; tick();
      for (int k = 0; k < 4; k++) begin
         lookup(32'h0050_0010 + (k << 10), $sformatf("tiny_inv_va_%0d", k), k != 1,
                (k != 1) ? 32'hE000_0010 + (k << 10) : 32'h0,
                (k != 1) ? 2'b10 : 2'b00, (k != 1) ? 4'hA : 4'h0,
                (k != 1) ? 2'b11 : 2'b00, (k != 1) ? 2'd3 : 2'd0);
         tick();
      end
      fill(32'h0060_0000, 2'd0, 22'h000001, 8'h00, 4'h0, 2'b00);
      i_inv_all = 1'b1; tick();
      lookup(32'h0050_0010, "inv_all_old_gone", 1'b0); tick();
      lookup(32'h0060_0000, "inv_all_drops_fill", 1'b0); tick();

      // Same-cycle ordering.
      fill(32'h0070_0000, 2'd2, 22'h044400, 8'h1B, 4'h1, 2'b00);
      lookup(32'h0070_0000, "fill_same_cycle_miss", 1'b0); tick();
      lookup(32'h0070_0000, "fill_next_cycle_hit", 1'b1, 32'h1110_0000, 2'b11, 4'h1, 2'b00, 2'd2); tick();
      fill(32'h0070_0000, 2'd2, 22'h088800, 8'h1B, 4'h2, 2'b01);
      i_inv_va_valid = 1'b1; i_inv_va = 32'h0070_0000; tick();
      lookup(32'h0070_0123, "fill_beats_inv_va", 1'b1, 32'h2220_0123, 2'b11, 4'h2, 2'b01, 2'd2); tick();

      // Hold freezes outputs while a fill still lands.
      i_hold = 1'b1; i_lkp_valid = 1'b1; i_lkp_va = 32'h0000_0000;
      push("hold_outputs_frozen", 1'b1, 32'h2220_0123, 2'b11, 4'h2, 2'b01, 2'd2);
      fill(32'h0090_0000, 2'd2, 22'h0CCC00, 8'h1B, 4'h4, 2'b10); tick();
      lookup(32'h0090_0ABC, "hold_fill_applied", 1'b1, 32'h3330_0ABC, 2'b01, 4'h4, 2'b10, 2'd2); tick();
      tick();

      // Reset arriving while a fill is pending discards it.
      fill(32'h00A0_0000, 2'd0, 22'h000005, 8'h00, 4'h0, 2'b00);
      #2 i_reset_n = 1'b0;
      tick();
      i_reset_n = 1'b1;
      lookup(32'h00A0_0000, "reset_drops_fill", 1'b0); tick();
      tick(); tick();

      check(sb_q.size() == 0, "scoreboard_drained", $sformatf("%0d pending", sb_q.size()), "0 pending");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
